// File: rtl/mips32_scoreboard_regfile.sv
// Multi-read-port register file with write-back bypass and a per-register
// pending-write scoreboard that flags RAW hazards to the decode stage.
module mips32_scoreboard_regfile #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned MAX_PEND  = 3,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_RD-1:0]                        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]                 rd_addr,
  output logic [NUM_RD*DATA_W-1:0]                 rd_data,
  output logic [NUM_RD-1:0]                        rd_busy,
  output logic                                     stall,
  input  logic                                     issue_valid,
  input  logic [ADDR_W-1:0]                        issue_dst,
  output logic                                     issue_ready,
  input  logic                                     wb_valid,
  input  logic [ADDR_W-1:0]                        wb_addr,
  input  logic [DATA_W-1:0]                        wb_data,
  output logic [ADDR_W+$clog2(MAX_PEND+1)-1:0]     pend_total,
  output logic                                     err_underflow,
  output logic                                     err_overflow
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam int unsigned CW    = $clog2(MAX_PEND + 1);
  localparam int unsigned TW    = ADDR_W + CW;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CW-1:0]     pend_q [NREGS];
  logic [CW-1:0]     pend_d [NREGS];
  logic [TW-1:0]     pend_total_q, pend_total_d;
  logic              err_underflow_q, err_underflow_d;
  logic              err_overflow_q, err_overflow_d;

  logic issue_acc;
  logic wb_live;
  logic wb_dec;

  // Claim acceptance ignores any same-cycle write-back to the same register.
  assign issue_ready = (issue_dst == '0) || (pend_q[issue_dst] != CW'(MAX_PEND));
  assign issue_acc   = issue_valid && issue_ready && (issue_dst != '0);
  assign wb_live     = wb_valid && (wb_addr != '0);
  assign wb_dec      = wb_live && (pend_q[wb_addr] != '0);

  // Read ports: R0 reads zero, a same-cycle write-back is forwarded, and a
  // register whose only outstanding write retires now is not reported busy.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a   = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit = wb_valid && (wb_addr == a);
    assign rd_data[i*DATA_W +: DATA_W] = (a == '0) ? '0 : (hit ? wb_data : regs_q[a]);
    assign rd_busy[i] = (a != '0) && (pend_q[a] > CW'(hit));
  end

  assign stall = |(rd_en & rd_busy);

  // Scoreboard next state: counter updates, error flags and the new total.
  always_comb begin
    err_underflow_d = err_underflow_q;
    err_overflow_d  = err_overflow_q;
    pend_total_d    = '0;
    for (int k = 0; k < NREGS; k++) begin
      pend_d[k] = pend_q[k]
                + CW'(issue_acc && (issue_dst == ADDR_W'(k)))
                - CW'(wb_dec && (wb_addr == ADDR_W'(k)));
    end
    for (int k = 0; k < NREGS; k++) begin
      pend_total_d = pend_total_d + TW'(pend_d[k]);
    end
    if (wb_live && !wb_dec) err_underflow_d = 1'b1;
    if (issue_valid && !issue_ready) err_overflow_d = 1'b1;
  end

  // State registers: register contents, pending counters, total and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= (INIT_MODE == 1 && k != 0) ? DATA_W'(k) : '0;
        pend_q[k] <= '0;
      end
      pend_total_q    <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      if (wb_live) regs_q[wb_addr] <= wb_data;
      pend_q          <= pend_d;
      pend_total_q    <= pend_total_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign pend_total    = pend_total_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule
